irq_exc_ctrl: RTL and testbench
===============================

// Module: irq_exc_ctrl
// PURPOSE
// Sequential interrupt/exception controller for the 5-stage pipeline; successor to the flat
// single-IRQ decode logic. Takes N external IRQ lines with mask/pending/priority, plus decode's
// undefined-instruction flag. Tracks kernel mode with an FSM and captures EPC/cause.
// Drives the ID-stage redirect (flush + vector PC) and blocks re-interrupt for a hold window
// after ERET.
// PARAMETERS
// N_IRQ     4             number of external interrupt lines; line 0 = highest priority
// PC_W      32            PC / EPC width
// VEC_INT   32'h80000004  interrupt handler vector
// VEC_EXC   32'h80000008  undefined-instruction handler vector
// HOLD_CYC  2             cycles interrupts stay blocked after ERET (0 = none; max 15)
// PORTS
// clk         in   1      clock, all state updates on posedge
// reset       in   1      asynchronous, active-low reset
// irq_i       in   N_IRQ  async level IRQ lines
// undef_i     in   1      ID instruction is undefined (from decode)
// id_pc_i     in   PC_W   PC of instruction in ID
// id_valid_i  in   1      ID holds a real (non-bubble) instruction
// stall_i     in   1      ID stalled this cycle; no event may be taken
// eret_i      in   1      ID instruction is ERET, accepted this cycle
// mask_we_i   in   1      write mask register
// mask_i      in   N_IRQ  new mask (1 = line masked)
// pend_clr_i  in   N_IRQ  one-hot/multi-hot clear of pending bits (handler ack)
// ker_o       out  1      1 in KERNEL state
// redirect_o  out  1      combinational: flush IF/ID, load vec_pc_o this cycle
// vec_pc_o    out  PC_W   VEC_INT or VEC_EXC; valid when redirect_o
// epc_o       out  PC_W   registered return PC
// cause_o     out  8      registered {exc, reserved[2:0], irq_idx[3:0]}
// pending_o   out  N_IRQ  registered pending bits
// mask_o      out  N_IRQ  registered mask
// dbl_fault_o out  1      sticky: undef_i seen in KERNEL
// BEHAVIOUR
// - Reset: state USER, ker_o 0, mask_o all 1, pending/epc/cause/hold count/sync flops 0,
//   dbl_fault_o 0.
// - IRQ path: 2-flop sync, then rising-edge detect; an edge sets pending[i] next edge.
//   Set and pend_clr_i on the same bit in the same cycle: set wins.
// - req_int = |(pending_o & ~mask_o). Winner = lowest index. Mask write takes effect next
//   cycle; a take in the write cycle uses the old mask.
// - accept = id_valid_i & ~stall_i. No take without accept.
// - USER: accept & req_int -> take INT (priority over undef_i).
//   * epc <= id_pc_i (instruction squashed, re-executed); cause <= {0,000,idx}.
//   * next KERNEL.
//   Else accept & undef_i -> take EXC.
//   * epc <= id_pc_i + 4 (mod 2^PC_W); cause <= 8'h80.
//   * next KERNEL.
// - KERNEL: no takes.
//   * accept & undef_i: set dbl_fault_o, instruction treated as NOP, epc/cause unchanged.
//   * accept & eret_i -> HOLD with count = HOLD_CYC, or USER if HOLD_CYC = 0.
// - HOLD: count decrements each cycle; at 1 -> USER.
//   * EXC is takeable (-> KERNEL, count cleared); INT deferred, pending retained.
// - redirect_o = take INT/EXC, combinational from registered state and inputs.
//   vec_pc_o is VEC_INT for INT, VEC_EXC for EXC.
// - ker_o is registered: it rises the cycle after redirect_o and falls the cycle after ERET
//   accept.
// - Async reset asserted mid-handler returns every register to its reset value; the
//   in-flight EPC is lost.
// STRUCTURE
// - Package irq_exc_pkg: state enum {USER,KERNEL,HOLD}, CAUSE_EXC = 8'h80, default vectors.
// - Sub-module irq_sync: 2-flop synchroniser + rise detect, one per line via generate.
// - Top level: pending/mask regs, priority encoder (for loop), FSM, EPC/cause regs,
//   hold counter.
// TESTING
// 1 irq_i[2] pulse, mask=0, accept, id_pc=0x100 -> redirect, vec=VEC_INT, epc=0x100,
//   cause=0x02, ker=1 next cycle.
// 2 irq_i[1] and irq_i[3] same cycle, USER -> cause=0x01; pending[3] stays 1.
// 3 undef_i and pending unmasked IRQ same cycle, pc=0x200 -> INT taken, epc=0x200;
//   after ERET + 2 hold cycles the re-executed undef -> EXC, epc=0x204.
// 4 ERET, then IRQ edge during HOLD_CYC=2 window -> no redirect for 2 cycles, INT taken
//   in cycle 3.
// 5 stall_i=1 with pending IRQ for 5 cycles -> redirect_o low throughout; taken when stall
//   drops. Also: undef in KERNEL -> dbl_fault_o=1, epc unchanged.
// 6 reset low while KERNEL -> ker=0, mask=all 1, pending=0 immediately (async); pc=0xFFFFFFFC
//   undef -> epc=0x0 (wrap).

Source files
------------

// File: rtl/irq_exc_pkg.sv
// Shared types and constants for the interrupt/exception controller.
package irq_exc_pkg;

  typedef enum logic [1:0] {
    USER   = 2'd0,
    KERNEL = 2'd1,
    HOLD   = 2'd2
  } state_e;

  localparam logic [7:0]  CAUSE_EXC   = 8'h80;
  localparam logic [31:0] DEF_VEC_INT = 32'h8000_0004;
  localparam logic [31:0] DEF_VEC_EXC = 32'h8000_0008;

  // Interrupt cause: exc bit clear, reserved zero, line index in the low nibble.
  function automatic logic [7:0] int_cause(input logic [3:0] idx);
    return {4'b0000, idx};
  endfunction

endpackage

// File: rtl/irq_sync.sv
// Two-flop synchroniser for one asynchronous IRQ line, followed by rising-edge detect.
module irq_sync (
  input  logic clk,
  input  logic reset,
  input  logic irq,
  output logic rise
);

  logic s1, s2, s3;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= irq;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise = s2 & ~s3;

endmodule

// File: rtl/irq_exc_ctrl.sv
// Interrupt/exception controller: pending/mask tracking, USER/KERNEL/HOLD mode FSM,
// EPC/cause capture and the ID-stage redirect.
module irq_exc_ctrl
  import irq_exc_pkg::*;
#(
  parameter int              N_IRQ    = 4,
  parameter int              PC_W     = 32,
  parameter logic [PC_W-1:0] VEC_INT  = DEF_VEC_INT,
  parameter logic [PC_W-1:0] VEC_EXC  = DEF_VEC_EXC,
  parameter int              HOLD_CYC = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_IRQ-1:0] irq_i,
  input  logic             undef_i,
  input  logic [PC_W-1:0]  id_pc_i,
  input  logic             id_valid_i,
  input  logic             stall_i,
  input  logic             eret_i,
  input  logic             mask_we_i,
  input  logic [N_IRQ-1:0] mask_i,
  input  logic [N_IRQ-1:0] pend_clr_i,
  output logic             ker_o,
  output logic             redirect_o,
  output logic [PC_W-1:0]  vec_pc_o,
  output logic [PC_W-1:0]  epc_o,
  output logic [7:0]       cause_o,
  output logic [N_IRQ-1:0] pending_o,
  output logic [N_IRQ-1:0] mask_o,
  output logic             dbl_fault_o,
  output state_e           fsm_state
);

  // Handshake: the ID instruction is accepted when id_valid_i is high and stall_i is low
  // in the same cycle; an event (take, ERET, double fault) only happens on an accept.
  logic accept;
  assign accept = id_valid_i & ~stall_i;

  logic [N_IRQ-1:0] rise;
  for (genvar g = 0; g < N_IRQ; g++) begin : g_sync
    irq_sync u_sync (
      .clk   (clk),
      .reset (reset),
      .irq   (irq_i[g]),
      .rise  (rise[g])
    );
  end

  logic [N_IRQ-1:0] req_vec;
  logic             req_int;
  logic [3:0]       req_idx;

  assign req_vec = pending_o & ~mask_o;
  assign req_int = |req_vec;

  // Scan downward so the lowest set index is the last assignment and wins.
  always_comb begin
    req_idx = 4'd0;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (req_vec[i]) req_idx = 4'(i);
    end
  end

  state_e     state, state_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic       take_int, take_exc, dbl_set;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    take_int  = 1'b0;
    take_exc  = 1'b0;
    dbl_set   = 1'b0;
    case (state)
      USER: begin
        if (accept && req_int) begin
          take_int  = 1'b1;
          state_nxt = KERNEL;
        end else if (accept && undef_i) begin
          take_exc  = 1'b1;
          state_nxt = KERNEL;
        end
      end
      KERNEL: begin
        if (accept && undef_i) dbl_set = 1'b1;
        if (accept && eret_i) begin
          if (HOLD_CYC == 0) begin
            state_nxt = USER;
          end else begin
            state_nxt = HOLD;
            cnt_nxt   = 4'(HOLD_CYC);
          end
        end
      end
      HOLD: begin
        // Interrupts stay deferred here; a faulting instruction still traps.
        if (accept && undef_i) begin
          take_exc  = 1'b1;
          state_nxt = KERNEL;
          cnt_nxt   = 4'd0;
        end else if (cnt <= 4'd1) begin
          state_nxt = USER;
          cnt_nxt   = 4'd0;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      default: begin
        state_nxt = USER;
        cnt_nxt   = 4'd0;
      end
    endcase
  end

  assign redirect_o = take_int | take_exc;
  assign vec_pc_o   = take_exc ? VEC_EXC : VEC_INT;
  assign fsm_state  = state;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= USER;
      cnt         <= 4'd0;
      ker_o       <= 1'b0;
      epc_o       <= '0;
      cause_o     <= 8'h00;
      pending_o   <= '0;
      mask_o      <= '1;
      dbl_fault_o <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      ker_o     <= (state_nxt == KERNEL);
      // A new edge outranks a handler ack on the same bit.
      pending_o <= (pending_o & ~pend_clr_i) | rise;
      if (mask_we_i) mask_o <= mask_i;
      if (dbl_set) dbl_fault_o <= 1'b1;
      if (take_int) begin
        epc_o   <= id_pc_i;
        cause_o <= int_cause(req_idx);
      end else if (take_exc) begin
        epc_o   <= id_pc_i + PC_W'(4);
        cause_o <= CAUSE_EXC;
      end
    end
  end

endmodule

// File: tb/tb_irq_exc_ctrl.sv
// Directed bench for irq_exc_ctrl: hand-computed expectations checked with immediate asserts.
module tb_irq_exc_ctrl;
  import irq_exc_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  irq_i;
  logic        undef_i;
  logic [31:0] id_pc_i;
  logic        id_valid_i;
  logic        stall_i;
  logic        eret_i;
  logic        mask_we_i;
  logic [3:0]  mask_i;
  logic [3:0]  pend_clr_i;
  logic        ker_o;
  logic        redirect_o;
  logic [31:0] vec_pc_o;
  logic [31:0] epc_o;
  logic [7:0]  cause_o;
  logic [3:0]  pending_o;
  logic [3:0]  mask_o;
  logic        dbl_fault_o;
  state_e      fsm_state;

  int errors = 0;
  int checks = 0;

  localparam logic [31:0] V_INT = 32'h8000_0004;
  localparam logic [31:0] V_EXC = 32'h8000_0008;

  irq_exc_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .irq_i       (irq_i),
    .undef_i     (undef_i),
    .id_pc_i     (id_pc_i),
    .id_valid_i  (id_valid_i),
    .stall_i     (stall_i),
    .eret_i      (eret_i),
    .mask_we_i   (mask_we_i),
    .mask_i      (mask_i),
    .pend_clr_i  (pend_clr_i),
    .ker_o       (ker_o),
    .redirect_o  (redirect_o),
    .vec_pc_o    (vec_pc_o),
    .epc_o       (epc_o),
    .cause_o     (cause_o),
    .pending_o   (pending_o),
    .mask_o      (mask_o),
    .dbl_fault_o (dbl_fault_o),
    .fsm_state   (fsm_state)
  );

  // Clock and reset
  always #5 clk = ~clk;

  // Driver tasks: inputs change 1 time unit after the rising edge, outputs sampled after that.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic pulse_irq(input logic [3:0] v);
    irq_i = v;
    step();
    irq_i = 4'h0;
    step();
    step();
  endtask

  task automatic do_eret();
    id_valid_i = 1'b1;
    eret_i     = 1'b1;
    step();
    id_valid_i = 1'b0;
    eret_i     = 1'b0;
    step();
    step();
  endtask

  initial begin
    reset = 1'b0;
    irq_i = 4'h0; undef_i = 1'b0; id_pc_i = 32'h0; id_valid_i = 1'b0;
    stall_i = 1'b0; eret_i = 1'b0; mask_we_i = 1'b0; mask_i = 4'h0; pend_clr_i = 4'h0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ker", 32'(ker_o), 32'd0);
    chk("rst_mask", 32'(mask_o), 32'hF);
    chk("rst_pend", 32'(pending_o), 32'h0);
    chk("rst_epc", epc_o, 32'h0);
    chk("rst_cause", 32'(cause_o), 32'h0);
    chk("rst_dbl", 32'(dbl_fault_o), 32'd0);
    chk("rst_redir", 32'(redirect_o), 32'd0);
    reset = 1'b1;
    step();

    // 1: single IRQ on line 2
    mask_we_i = 1'b1; mask_i = 4'h0;
    step();
    mask_we_i = 1'b0;
    chk("t1_mask", 32'(mask_o), 32'h0);
    pulse_irq(4'b0100);
    chk("t1_pend", 32'(pending_o), 32'h4);
    id_valid_i = 1'b1; id_pc_i = 32'h100;
    settle();
    chk("t1_redir", 32'(redirect_o), 32'd1);
    chk("t1_vec", vec_pc_o, V_INT);
    chk("t1_ker_pre", 32'(ker_o), 32'd0);
    step();
    id_valid_i = 1'b0;
    chk("t1_epc", epc_o, 32'h100);
    chk("t1_cause", 32'(cause_o), 32'h02);
    chk("t1_ker", 32'(ker_o), 32'd1);
    chk("t1_state", 32'(fsm_state), 32'(KERNEL));
    pend_clr_i = 4'h4;
    step();
    pend_clr_i = 4'h0;
    chk("t1_clr", 32'(pending_o), 32'h0);
    id_valid_i = 1'b1; eret_i = 1'b1;
    step();
    id_valid_i = 1'b0; eret_i = 1'b0;
    chk("t1_ker_eret", 32'(ker_o), 32'd0);
    chk("t1_hold", 32'(fsm_state), 32'(HOLD));
    step();
    step();
    chk("t1_user", 32'(fsm_state), 32'(USER));

    // 2: lines 1 and 3 together, lowest index wins
    pulse_irq(4'b1010);
    chk("t2_pend", 32'(pending_o), 32'hA);
    id_valid_i = 1'b1; id_pc_i = 32'h300;
    settle();
    chk("t2_redir", 32'(redirect_o), 32'd1);
    step();
    id_valid_i = 1'b0;
    chk("t2_cause", 32'(cause_o), 32'h01);
    chk("t2_epc", epc_o, 32'h300);
    chk("t2_pend3", 32'(pending_o), 32'hA);
    pend_clr_i = 4'hA;
    step();
    pend_clr_i = 4'h0;
    do_eret();

    // 3: undef with pending IRQ -> INT first, then re-executed undef -> EXC
    pulse_irq(4'b0001);
    id_valid_i = 1'b1; undef_i = 1'b1; id_pc_i = 32'h200;
    settle();
    chk("t3_redir", 32'(redirect_o), 32'd1);
    chk("t3_vec", vec_pc_o, V_INT);
    step();
    id_valid_i = 1'b0; undef_i = 1'b0;
    chk("t3_epc", epc_o, 32'h200);
    chk("t3_cause", 32'(cause_o), 32'h00);
    chk("t3_dbl", 32'(dbl_fault_o), 32'd0);
    pend_clr_i = 4'h1;
    step();
    pend_clr_i = 4'h0;
    do_eret();
    id_valid_i = 1'b1; undef_i = 1'b1; id_pc_i = 32'h200;
    settle();
    chk("t3_redir_exc", 32'(redirect_o), 32'd1);
    chk("t3_vec_exc", vec_pc_o, V_EXC);
    step();
    id_valid_i = 1'b0; undef_i = 1'b0;
    chk("t3_epc_exc", epc_o, 32'h204);
    chk("t3_cause_exc", 32'(cause_o), 32'h80);
    chk("t3_ker_exc", 32'(ker_o), 32'd1);

    // 4: IRQ pending across the hold window after ERET
    irq_i = 4'b0010;
    step();
    irq_i = 4'h0;
    step();
    id_valid_i = 1'b1; eret_i = 1'b1; id_pc_i = 32'h400;
    step();
    eret_i = 1'b0;
    settle();
    chk("t4_hold1_redir", 32'(redirect_o), 32'd0);
    chk("t4_hold1_ker", 32'(ker_o), 32'd0);
    chk("t4_hold1_pend", 32'(pending_o), 32'h2);
    step();
    settle();
    chk("t4_hold2_redir", 32'(redirect_o), 32'd0);
    step();
    settle();
    chk("t4_take_redir", 32'(redirect_o), 32'd1);
    chk("t4_take_vec", vec_pc_o, V_INT);
    step();
    id_valid_i = 1'b0;
    chk("t4_cause", 32'(cause_o), 32'h01);
    chk("t4_epc", epc_o, 32'h400);
    chk("t4_ker", 32'(ker_o), 32'd1);
    pend_clr_i = 4'h2;
    step();
    pend_clr_i = 4'h0;
    do_eret();

    // 5: stalled ID blocks the take; undef in KERNEL is a double fault
    pulse_irq(4'b1000);
    id_valid_i = 1'b1; stall_i = 1'b1; id_pc_i = 32'h500;
    for (int i = 0; i < 5; i++) begin
      settle();
      chk("t5_stall_redir", 32'(redirect_o), 32'd0);
      step();
    end
    stall_i = 1'b0;
    settle();
    chk("t5_redir", 32'(redirect_o), 32'd1);
    step();
    chk("t5_epc", epc_o, 32'h500);
    chk("t5_cause", 32'(cause_o), 32'h03);
    undef_i = 1'b1; id_pc_i = 32'h600;
    settle();
    chk("t5_k_redir", 32'(redirect_o), 32'd0);
    step();
    id_valid_i = 1'b0; undef_i = 1'b0;
    chk("t5_dbl", 32'(dbl_fault_o), 32'd1);
    chk("t5_epc_keep", epc_o, 32'h500);
    chk("t5_cause_keep", 32'(cause_o), 32'h03);
    chk("t5_ker_keep", 32'(ker_o), 32'd1);

    // 6: async reset mid-handler, then EPC wrap on undef at the top of memory
    #1;
    reset = 1'b0;
    #1;
    chk("t6_ker", 32'(ker_o), 32'd0);
    chk("t6_mask", 32'(mask_o), 32'hF);
    chk("t6_pend", 32'(pending_o), 32'h0);
    chk("t6_epc", epc_o, 32'h0);
    chk("t6_dbl", 32'(dbl_fault_o), 32'd0);
    chk("t6_state", 32'(fsm_state), 32'(USER));
    step();
    reset = 1'b1;
    step();
    id_valid_i = 1'b1; undef_i = 1'b1; id_pc_i = 32'hFFFF_FFFC;
    settle();
    chk("t6_redir", 32'(redirect_o), 32'd1);
    chk("t6_vec", vec_pc_o, V_EXC);
    step();
    id_valid_i = 1'b0; undef_i = 1'b0;
    chk("t6_epc_wrap", epc_o, 32'h0);
    chk("t6_cause", 32'(cause_o), 32'h80);

    // Final report
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
